seq_multiplier_32: RTL and testbench

SEQ_MULTIPLIER_32 -- requirements
Module: seq_multiplier_32

---
 rtl/seq_mult_pkg.sv | 19 +
 rtl/mult_add_32.sv | 16 +
 rtl/seq_multiplier_32.sv | 111 +++++++++++
 tb/tb_seq_multiplier_32.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/seq_mult_pkg.sv
// rtl/seq_mult_pkg.sv - shared state encoding and sizing constants for the sequential multiplier
package seq_mult_pkg;

    localparam int WIDTH_DEFAULT = 32;

    // Iteration counter must reach WIDTH itself, hence the extra bit.
    function automatic int count_width(input int w);
        return $clog2(w) + 1;
    endfunction

    localparam int CNT_W = count_width(WIDTH_DEFAULT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mult_add_32.sv
// rtl/mult_add_32.sv - combinational accumulate adder with carry-out for the shift-and-add step
module mult_add_32
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};

endmodule

// File: rtl/seq_multiplier_32.sv
// rtl/seq_multiplier_32.sv - unsigned shift-and-add multiplier, one bit per cycle
// Optional early termination on exhausted multiplier bits: SEQ_MULT_EARLY_TERM_EN
module seq_multiplier_32
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = count_width(WIDTH);

    state_t             state;
    state_t             state_nxt;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic [WIDTH-1:0]   acc_hi;
    logic [WIDTH-1:0]   add_sum;
    logic               add_cout;
    logic [CW-1:0]      count;
    logic [WIDTH:0]     hi_sel;
    logic [2*WIDTH-1:0] result;
    logic               finish;
    logic               accept;

    mult_add_32 #(.WIDTH(WIDTH)) u_add (
        .a    (acc_hi),
        .b    (mcand),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Carry lands in the top bit before the right shift, so it is never lost.
    always_comb begin
        hi_sel = mplier[0] ? {add_cout, add_sum} : {1'b0, acc_hi};
        result = {hi_sel, mplier[WIDTH-1:1]};
        finish = (count == CW'(WIDTH - 1));
`ifdef SEQ_MULT_EARLY_TERM_EN
        if ((mplier & ({WIDTH{1'b1}} >> count)) == '0) begin
            result = {acc_hi, mplier} >> (CW'(WIDTH) - count);
            finish = 1'b1;
        end
`endif
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (finish) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // product is a separate register so it stays put while the next operation runs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            mcand   <= '0;
            mplier  <= '0;
            acc_hi  <= '0;
            count   <= '0;
            product <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                mcand  <= a;
                mplier <= b;
                acc_hi <= '0;
                count  <= '0;
            end else if (state == RUN) begin
                {acc_hi, mplier} <= result;
                count            <= count + 1'b1;
                if (finish) begin
                    product <= result;
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_multiplier_32.sv
// tb/tb_seq_multiplier_32.sv - directed scoreboard bench for seq_multiplier_32
module tb_seq_multiplier_32;

    localparam int W = 32;

    typedef struct {
        logic [63:0] prod;
        int          acc_edge;
        int          lat;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          busy;
    logic          done;
    logic [63:0]   product;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    exp_t sb[$];

    seq_multiplier_32 dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_lat(input logic [W-1:0] bv);
`ifdef SEQ_MULT_EARLY_TERM_EN
        int n;
        n = 0;
        for (int i = 0; i < W; i++) if (bv[i]) n = i + 1;
        return (n + 1 > W) ? W : n + 1;
`else
        return W;
`endif
    endfunction

    // Every done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            chk("done_busy_excl", {63'd0, busy}, 64'd0);
            if (sb.size() == 0) begin
                chk("unexpected_done", {63'd0, done}, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("product", product, e.prod);
                chk("latency", 64'(cyc - e.acc_edge), 64'(e.lat));
            end
        end
    end

    task automatic push_exp(input logic [W-1:0] av, input logic [W-1:0] bv);
        exp_t e;
        e.prod     = 64'(av) * 64'(bv);
        e.acc_edge = cyc + 1;
        e.lat      = exp_lat(bv);
        sb.push_back(e);
    endtask

    task automatic launch(input logic [W-1:0] av, input logic [W-1:0] bv);
        a     = av;
        b     = bv;
        start = 1'b1;
        push_exp(av, bv);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("drain_timeout", {63'd0, sb.size() == 0}, 64'd1);
        @(negedge clk);
    endtask

    initial begin
        logic [63:0] first;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        repeat (3) @(negedge clk);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_product", product, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        launch(32'd3, 32'd5);
        drain();
        launch(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        drain();
        chk("allones_held", product, 64'hFFFF_FFFE_0000_0001);

        // A second start inside RUN must be ignored.
        launch(32'h10, 32'h20);
        repeat (4) @(negedge clk);
        a     = 32'd7;
        b     = 32'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("ignored_start_busy", {63'd0, busy}, 64'd1);
        drain();
        chk("ignored_start_product", product, 64'h200);

        // Reset mid-run aborts without a done pulse.
        a     = 32'hABCD;
        b     = 32'h1234;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_done", {63'd0, done}, 64'd0);
        chk("abort_product", product, 64'd0);
        repeat (40) @(negedge clk);
        launch(32'hABCD, 32'h1234);
        drain();

        // Start held high across done gives back-to-back operations.
        first = 64'd1000 * 64'd3000;
        a     = 32'd1000;
        b     = 32'd3000;
        start = 1'b1;
        push_exp(32'd1000, 32'd3000);
        @(negedge clk);
        a = 32'h8765_4321;
        b = 32'hDEAD_BEEF;
        for (int i = 0; i < 40 && !done; i++) @(negedge clk);
        chk("b2b_done_seen", {63'd0, done}, 64'd1);
        push_exp(32'h8765_4321, 32'hDEAD_BEEF);
        @(negedge clk);
        start = 1'b0;
        chk("b2b_done_pulse", {63'd0, done}, 64'd0);
        chk("b2b_busy", {63'd0, busy}, 64'd1);
        repeat (10) @(negedge clk);
        chk("b2b_product_held", product, first);
        drain();

        launch(32'h1234, 32'd0);
        drain();
        launch(32'h1234, 32'h8000_0000);
        drain();
        launch(32'h5555_AAAA, 32'd1);
        drain();

        for (int i = 0; i < 4; i++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            launch(ra, rb);
            drain();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
